vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter HS_POL, 0, asserted level of out_hsync (0 = active-low).
REQ-010 Parameter VS_POL, 0, asserted level of out_vsync.
REQ-011 Parameter PIPE_DLY, 0, extra strobe delay (0..7) on sync/blank/active relative to coordinates.
REQ-012 Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = clog2(H_TOTAL); YW = clog2(V_TOTAL).
REQ-013 in_clock  input  1  single clock, all state on rising edge.
REQ-014 in_reset  input  1  asynchronous, active-high reset.
REQ-015 in_strobe  input  1  pixel-enable; one pixel position per cycle where high.
REQ-016 out_hsync / out_vsync  output  1 each  sync pulses at HS_POL / VS_POL.
REQ-017 out_blank / out_active  output  1 each  outside / inside visible region; always complementary.
REQ-018 out_x  output  XW  horizontal counter; out_y  output  YW  vertical counter.
REQ-019 out_line_end / out_frame_end / out_anim  output  1 each  single-cycle event pulses.
REQ-020 out_frame  output  8  frame counter.

Function
REQ-021 h_cnt counts 0..H_TOTAL-1 on each strobe, wraps to 0; v_cnt increments on that wrap, counts 0..V_TOTAL-1, wraps to 0.
REQ-022 Line layout: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; vertical identical with V_* values.
REQ-023 All outputs are registered, updated only in clock cycles with in_strobe=1, from decode of pre-increment counter values (one strobe latency).
REQ-024 out_x/out_y present raw h_cnt/v_cnt, including blanking; no clamping.
REQ-025 out_active = (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE); out_blank = NOT out_active.
REQ-026 With PIPE_DLY = N > 0, hsync, vsync, blank and active pass through an N-stage shift register advanced only on strobe; x, y and pulses are not delayed.
REQ-027 out_line_end pulses one clock after a strobe that decoded h_cnt = H_TOTAL-1; deasserts next clock regardless of strobe.
REQ-028 out_frame_end pulses likewise when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
REQ-029 out_anim pulses likewise when h_cnt = H_TOTAL-1 and v_cnt = V_ACTIVE-1 (start of vertical blank).
REQ-030 out_frame increments with each out_frame_end, 255 -> 0 wrap.
REQ-031 in_strobe low: counters, levels and delay stages hold; pulses clear.
REQ-032 Simultaneous line and frame wrap: both pulses assert in the same cycle, out_frame increments once.

Reset
REQ-033 in_reset asserted at any time, mid-frame included, immediately clears h_cnt, v_cnt, out_x, out_y, out_frame, all pulses and all delay stages.
REQ-034 Reset values: out_hsync = ~HS_POL, out_vsync = ~VS_POL, out_blank = 1, out_active = 0; delay stages reset to those same values.
REQ-035 First strobe after reset release presents x=0, y=0, active=1 (PIPE_DLY=0).

Verification
REQ-036 Defaults, strobe every 4th clock -> line 800 strobes, out_hsync low for x in 656..751, frame 420000 strobes, out_vsync low for y 490..491.
REQ-037 Defaults, strobe tied high -> out_anim once per frame at x=799,y=479; out_frame_end at x=799,y=524; out_frame 255 -> 0 after 256 frames.
REQ-038 PIPE_DLY=2 -> out_active rises 2 strobes after out_x=0,y=0; hsync edges shifted 2 strobes vs REQ-036.
REQ-039 HS_POL=1, VS_POL=1 -> syncs high only in sync windows; reset value 0.
REQ-040 Reset asserted at x=300,y=200 asynchronously between edges -> outputs at REQ-034 values before next clock edge; restart at (0,0).
REQ-041 in_strobe held low 1000 clocks mid-line -> all level outputs frozen, no pulses, resumes at next position.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel strobe in, sync/blank/coordinate/event outputs of vga_timing_gen.
interface vga_timing_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          in_strobe;
    logic          out_hsync;
    logic          out_vsync;
    logic          out_blank;
    logic          out_active;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_line_end;
    logic          out_frame_end;
    logic          out_anim;
    logic [7:0]    out_frame;
    modport master (
        input  in_strobe,
        output out_hsync, out_vsync, out_blank, out_active, out_x, out_y,
        output out_line_end, out_frame_end, out_anim, out_frame
    );
    modport slave (
        output in_strobe,
        input  out_hsync, out_vsync, out_blank, out_active, out_x, out_y,
        input  out_line_end, out_frame_end, out_anim, out_frame
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: strobe-driven VGA raster counters with registered sync/blank levels and event pulses.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input logic          in_clock,
    input logic          in_reset,
    vga_timing_if.master bus
);
    localparam logic [2:0] LVL_RST = {~HS_POL, ~VS_POL, 1'b0};
    logic [XW-1:0] h_q, h_d, x_q;
    logic [YW-1:0] v_q, v_d, y_q;
    logic [7:0]    frame_q;
    logic          le_q, fe_q, anim_q, h_last, v_last;
    logic [2:0]    lvl_d;
    // {hsync, vsync, active}; stage 0 is the plain registered decode, extra stages add delay
    logic [2:0]    pipe_q [PIPE_DLY+1];
    always_comb begin
        h_last = h_q == XW'(H_TOTAL - 1);
        v_last = v_q == YW'(V_TOTAL - 1);
        h_d    = h_last ? '0 : h_q + XW'(1);
        v_d    = h_last ? (v_last ? '0 : v_q + YW'(1)) : v_q;
        lvl_d  = {(h_q >= XW'(H_ACTIVE + H_FP) && h_q < XW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL,
                  (v_q >= YW'(V_ACTIVE + V_FP) && v_q < YW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL,
                  h_q < XW'(H_ACTIVE) && v_q < YW'(V_ACTIVE)};
    end
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            h_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            le_q    <= 1'b0;
            fe_q    <= 1'b0;
            anim_q  <= 1'b0;
            for (int i = 0; i <= PIPE_DLY; i++) pipe_q[i] <= LVL_RST;
        end else begin
            le_q   <= bus.in_strobe && h_last;
            fe_q   <= bus.in_strobe && h_last && v_last;
            anim_q <= bus.in_strobe && h_last && v_q == YW'(V_ACTIVE - 1);
            if (bus.in_strobe) begin
                h_q       <= h_d;
                v_q       <= v_d;
                x_q       <= h_q;
                y_q       <= v_q;
                frame_q   <= (h_last && v_last) ? frame_q + 8'd1 : frame_q;
                pipe_q[0] <= lvl_d;
                for (int i = 1; i <= PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
    end
    assign bus.out_hsync     = pipe_q[PIPE_DLY][2];
    assign bus.out_vsync     = pipe_q[PIPE_DLY][1];
    assign bus.out_active    = pipe_q[PIPE_DLY][0];
    assign bus.out_blank     = ~pipe_q[PIPE_DLY][0];
    assign bus.out_x         = x_q;
    assign bus.out_y         = y_q;
    assign bus.out_line_end  = le_q;
    assign bus.out_frame_end = fe_q;
    assign bus.out_anim      = anim_q;
    assign bus.out_frame     = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default 640x480 instance and two small-raster instances.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stb = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   p, hx, vy, d, dx, dy, cnt_le, cnt_fe, cnt_anim;
    bit   ea, eh, ev;
    always #5 clk = ~clk;
    vga_timing_if #(.XW(10), .YW(10)) if0 ();
    vga_timing_if #(.XW(3), .YW(3)) if1 ();
    vga_timing_if #(.XW(3), .YW(3)) if2 ();
    assign if0.in_strobe = stb;
    assign if1.in_strobe = stb;
    assign if2.in_strobe = stb;
    vga_timing_gen u0 (.in_clock(clk), .in_reset(rst), .bus(if0));
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1))
        u1 (.in_clock(clk), .in_reset(rst), .bus(if1));
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(2))
        u2 (.in_clock(clk), .in_reset(rst), .bus(if2));
    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input logic s);
        stb = s;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic adv(input int k);
        repeat (k) begin
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
            tick(1'b0);
        end
    endtask
    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hs", if0.out_hsync, 1);
        chk("rst_vs", if0.out_vsync, 1);
        chk("rst_blank", if0.out_blank, 1);
        chk("rst_act", if0.out_active, 0);
        chk("rst_x", if0.out_x, 0);
        chk("rst_y", if0.out_y, 0);
        chk("rst_frame", if0.out_frame, 0);
        chk("rst_pulses", {if0.out_line_end, if0.out_frame_end, if0.out_anim}, 0);
        chk("rst_hs_pol1", if2.out_hsync, 0);
        chk("rst_vs_pol1", if2.out_vsync, 0);
        rst = 1'b0;
        tick(1'b1);
        chk("first_x", if0.out_x, 0);
        chk("first_y", if0.out_y, 0);
        chk("first_act", if0.out_active, 1);
        chk("first_blank", if0.out_blank, 0);
        chk("first_hs", if0.out_hsync, 1);
        repeat (3) tick(1'b0);
        adv(655);
        chk("x655", if0.out_x, 655);
        chk("hs655", if0.out_hsync, 1);
        adv(1);
        chk("hs656", if0.out_hsync, 0);
        chk("blank656", if0.out_blank, 1);
        adv(95);
        chk("x751", if0.out_x, 751);
        chk("hs751", if0.out_hsync, 0);
        adv(1);
        chk("hs752", if0.out_hsync, 1);
        adv(46);
        tick(1'b1);
        chk("x799", if0.out_x, 799);
        chk("le799", if0.out_line_end, 1);
        chk("anim_y0", if0.out_anim, 0);
        tick(1'b0);
        chk("le_clear", if0.out_line_end, 0);
        repeat (2) tick(1'b0);
        adv(1);
        chk("wrap_x", if0.out_x, 0);
        chk("wrap_y", if0.out_y, 1);
        chk("wrap_act", if0.out_active, 1);
        adv(299);
        cnt_le = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0);
            cnt_le += int'(if0.out_line_end) + int'(if0.out_frame_end) + int'(if0.out_anim);
        end
        chk("frz_x", if0.out_x, 299);
        chk("frz_y", if0.out_y, 1);
        chk("frz_hs", if0.out_hsync, 1);
        chk("frz_act", if0.out_active, 1);
        chk("frz_pulses", cnt_le, 0);
        tick(1'b1);
        chk("resume_x", if0.out_x, 300);
        chk("resume_y", if0.out_y, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_x", if0.out_x, 0);
        chk("arst_y", if0.out_y, 0);
        chk("arst_act", if0.out_active, 0);
        chk("arst_blank", if0.out_blank, 1);
        chk("arst_hs", if0.out_hsync, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 48; n++) begin
            tick(1'b1);
            if (n == 1) begin
                chk("restart_x", if0.out_x, 0);
                chk("restart_y", if0.out_y, 0);
                chk("restart_act", if0.out_active, 1);
            end
            p = n - 1;
            hx = p % 8;
            vy = p / 8;
            chk("s_x", if1.out_x, hx);
            chk("s_y", if1.out_y, vy);
            chk("s_act", if1.out_active, int'(hx < 4 && vy < 3));
            chk("s_blank", if1.out_blank, int'(!(hx < 4 && vy < 3)));
            chk("s_hs", if1.out_hsync, int'(!(hx >= 5 && hx < 7)));
            chk("s_vs", if1.out_vsync, int'(vy != 4));
            chk("s_le", if1.out_line_end, int'(hx == 7));
            chk("s_fe", if1.out_frame_end, int'(p == 47));
            chk("s_anim", if1.out_anim, int'(hx == 7 && vy == 2));
            chk("s_frame", if1.out_frame, n / 48);
            d = p - 2;
            dx = (d < 0) ? 0 : d % 8;
            dy = (d < 0) ? 0 : d / 8;
            ea = d >= 0 && dx < 4 && dy < 3;
            eh = d >= 0 && dx >= 5 && dx < 7;
            ev = d >= 0 && dy == 4;
            chk("d_x", if2.out_x, hx);
            chk("d_act", if2.out_active, int'(ea));
            chk("d_blank", if2.out_blank, int'(!ea));
            chk("d_hs", if2.out_hsync, int'(eh));
            chk("d_vs", if2.out_vsync, int'(ev));
        end
        cnt_fe = 0;
        cnt_anim = 0;
        for (int n = 49; n < 48 * 256; n++) begin
            tick(1'b1);
            cnt_fe += int'(if1.out_frame_end);
            cnt_anim += int'(if1.out_anim);
        end
        chk("cnt_anim", cnt_anim, 255);
        chk("cnt_fe", cnt_fe, 254);
        chk("frame255", if1.out_frame, 255);
        tick(1'b1);
        chk("frame_wrap", if1.out_frame, 0);
        chk("wrap_fe", if1.out_frame_end, 1);
        chk("wrap_le", if1.out_line_end, 1);
        chk("wrap_anim", if1.out_anim, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
